// File: rtl/mandel_scan_ctrl.sv
// Frame sequencer for the Mandelbrot renderer: walks the raster,
// requests escape counts for each c, and plots the mapped colour.
module mandel_scan_ctrl #(
  parameter int unsigned        W        = 160,
  parameter int unsigned        H        = 120,
  parameter logic [7:0]         MAX_ITER = 8'd32,
  parameter logic signed [31:0] XMIN     = -(32'sd2 <<< 22),
  parameter logic signed [31:0] YMAX     = (32'sd1 <<< 22),
  parameter logic signed [31:0] DX       = 32'((64'd4 << 22) / 64'(W)),
  parameter logic signed [31:0] DY       = 32'((64'd2 << 22) / 64'(H))
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        done,
  output logic        eng_req_valid,
  input  logic        eng_req_ready,
  output logic [31:0] eng_cx,
  output logic [31:0] eng_cy,
  input  logic        eng_rsp_valid,
  input  logic [7:0]  eng_iters,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot
);

  localparam logic [8:0] XLAST = 9'(W - 1);
  localparam logic [7:0] YLAST = 8'(H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PLOT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [8:0]         r_x;
  logic [7:0]         r_y;
  logic signed [31:0] r_cx;
  logic signed [31:0] r_cy;
  logic               r_done;
  logic               r_valid;
  logic               r_plot;
  logic [8:0]         r_vx;
  logic [7:0]         r_vy;
  logic [2:0]         r_colour;

  logic               w_accept;
  logic               w_x_last;
  logic               w_y_last;
  logic [2:0]         w_colour;

  assign w_accept = r_valid & eng_req_ready;
  assign w_x_last = (r_x >= XLAST);
  assign w_y_last = (r_y >= YLAST);

  // Counts at or beyond the limit are "in set" and drawn black.
  assign w_colour = (eng_iters >= MAX_ITER) ? 3'b000
                                            : eng_iters[2:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_plot   <= 1'b0;
      r_vx     <= '0;
      r_vy     <= '0;
      r_colour <= '0;
    end else begin
      r_plot <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_x    <= '0;
          r_y    <= '0;
          r_cx   <= XMIN;
          r_cy   <= YMAX;
          r_done <= 1'b0;
          if (start) begin
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eng_rsp_valid) begin
            r_colour <= w_colour;
            r_vx     <= r_x;
            r_vy     <= r_y;
            r_plot   <= 1'b1;
            r_state  <= S_PLOT;
          end
        end
        S_PLOT: begin
          if (!w_x_last) begin
            r_x     <= r_x + 9'd1;
            r_cx    <= r_cx + DX;
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end else if (!w_y_last) begin
            r_x     <= '0;
            r_cx    <= XMIN;
            r_y     <= r_y + 8'd1;
            r_cy    <= r_cy - DY;
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // A new frame needs start to fall first.
          if (!start) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign done          = r_done;
  assign eng_req_valid = r_valid;
  assign eng_cx        = r_cx;
  assign eng_cy        = r_cy;
  assign vga_x         = r_vx;
  assign vga_y         = r_vy;
  assign vga_colour    = r_colour;
  assign vga_plot      = r_plot;

endmodule

// File: tb/tb_mandel_scan_ctrl.sv
// Directed bench for mandel_scan_ctrl on a 4x3 frame with
// unit steps and a scripted escape engine.
module tb_mandel_scan_ctrl;

  localparam logic [31:0] STEP = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic        eng_req_valid;
  logic        eng_req_ready = 1'b0;
  logic [31:0] eng_cx;
  logic [31:0] eng_cy;
  logic        eng_rsp_valid = 1'b0;
  logic [7:0]  eng_iters = 8'd0;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int checks = 0;
  int errors = 0;

  bit          eng_on = 1'b0;
  int          stall_n = 0;
  int          stall = 0;
  logic [7:0]  iters_tab[$];
  int          iters_idx = 0;
  int          cyc = 0;
  bit          seen_valid = 1'b0;
  logic [31:0] prev_cx = '0;
  logic [31:0] prev_cy = '0;
  int          bp_viol = 0;
  int          plot_bad = 0;
  int          stall_edges = 0;
  int          q_x[$];
  int          q_y[$];
  int          q_c[$];
  int          q_cyc[$];
  logic [31:0] a_cx[$];
  logic [31:0] a_cy[$];
  bit          done_seen = 1'b0;
  int          done_cyc = 0;

  logic [31:0] cx_tab[4] = '{32'h0000_0000, 32'h0040_0000,
                             32'h0080_0000, 32'h00C0_0000};
  logic [31:0] cy_tab[3] = '{32'h0000_0000, 32'hFFC0_0000,
                             32'hFF80_0000};

  mandel_scan_ctrl #(
    .W(4), .H(3), .MAX_ITER(8'd32),
    .XMIN(32'sh0), .YMAX(32'sh0),
    .DX(STEP), .DY(STEP)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .done(done),
    .eng_req_valid(eng_req_valid),
    .eng_req_ready(eng_req_ready),
    .eng_cx(eng_cx), .eng_cy(eng_cy),
    .eng_rsp_valid(eng_rsp_valid),
    .eng_iters(eng_iters),
    .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  initial forever #5 clk = ~clk;

  // Monitor and engine model, both working on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (vga_plot) begin
        q_x.push_back(int'(vga_x));
        q_y.push_back(int'(vga_y));
        q_c.push_back(int'(vga_colour));
        q_cyc.push_back(cyc);
        if (!eng_rsp_valid) plot_bad++;
      end
      if (seen_valid && eng_req_ready) begin
        a_cx.push_back(prev_cx);
        a_cy.push_back(prev_cy);
      end
      if (seen_valid && !eng_req_ready && rstn) begin
        stall_edges++;
        if (!eng_req_valid || eng_cx !== prev_cx ||
            eng_cy !== prev_cy) bp_viol++;
      end
      if (done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc = cyc;
      end
      if (eng_on) begin
        if (seen_valid && eng_req_ready) begin
          eng_req_ready = 1'b0;
          stall = 0;
          eng_rsp_valid = 1'b1;
          eng_iters = iters_tab[iters_idx % iters_tab.size()];
          iters_idx++;
        end else begin
          eng_rsp_valid = 1'b0;
          if (eng_req_valid && stall < stall_n) begin
            stall++;
            eng_req_ready = 1'b0;
          end else begin
            eng_req_ready = eng_req_valid;
          end
        end
      end
      seen_valid = eng_req_valid;
      prev_cx = eng_cx;
      prev_cy = eng_cy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    q_x.delete(); q_y.delete(); q_c.delete(); q_cyc.delete();
    a_cx.delete(); a_cy.delete();
    bp_viol = 0; plot_bad = 0; stall_edges = 0;
    done_seen = 1'b0; iters_idx = 0; stall = 0;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (done_seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL rst_done got %b want 0", done); end
    checks++; if (eng_req_valid !== 1'b0) begin errors++;
      $display("FAIL rst_valid got %b want 0", eng_req_valid); end
    checks++; if (vga_plot !== 1'b0) begin errors++;
      $display("FAIL rst_plot got %b want 0", vga_plot); end
    checks++; if (vga_x !== 9'd0 || vga_y !== 8'd0) begin errors++;
      $display("FAIL rst_xy got %0d,%0d want 0,0", vga_x, vga_y); end
    checks++; if (vga_colour !== 3'd0) begin errors++;
      $display("FAIL rst_colour got %0d want 0", vga_colour); end
    checks++; if (eng_cx !== 32'd0 || eng_cy !== 32'd0) begin errors++;
      $display("FAIL rst_c got %h,%h want 0,0", eng_cx, eng_cy); end
    rstn = 1'b1;
    tick(); tick();
    checks++; if (eng_req_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet got v=%b d=%b want 0,0",
               eng_req_valid, done); end
  endtask

  task automatic test_small_frame();
    bit ok;
    clear_logs();
    iters_tab = '{8'd5};
    stall_n = 0;
    eng_on = 1'b1;
    start = 1'b1;
    tick();
    checks++; if (eng_req_valid !== 1'b1) begin errors++;
      $display("FAIL start_to_valid got %b want 1", eng_req_valid); end
    wait_done(200, ok);
    checks++; if (!ok) begin errors++;
      $display("FAIL frame_done got timeout want done"); end
    checks++; if (q_x.size() != 12) begin errors++;
      $display("FAIL plot_count got %0d want 12", q_x.size()); end
    for (int i = 0; i < q_x.size(); i++) begin
      checks++;
      if (q_x[i] != i % 4 || q_y[i] != i / 4 || q_c[i] != 5) begin
        errors++;
        $display("FAIL raster_%0d got (%0d,%0d) c%0d want (%0d,%0d) c5",
                 i, q_x[i], q_y[i], q_c[i], i % 4, i / 4);
      end
    end
    for (int i = 1; i < q_cyc.size(); i++) begin
      checks++;
      if (q_cyc[i] - q_cyc[i-1] != 3) begin
        errors++;
        $display("FAIL pixel_period_%0d got %0d want 3",
                 i, q_cyc[i] - q_cyc[i-1]);
      end
    end
    if (q_cyc.size() == 12) begin
      checks++;
      if (done_cyc != q_cyc[11] + 1) begin
        errors++;
        $display("FAIL done_latency got %0d want %0d",
                 done_cyc, q_cyc[11] + 1);
      end
    end
    checks++; if (done !== 1'b1) begin errors++;
      $display("FAIL done_held got %b want 1", done); end
    start = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL done_fall got %b want 0", done); end
  endtask

  task automatic test_coords();
    bit ok;
    clear_logs();
    start = 1'b1;
    wait_done(200, ok);
    checks++; if (!ok || a_cx.size() != 12) begin errors++;
      $display("FAIL coord_count got %0d want 12", a_cx.size()); end
    for (int i = 0; i < a_cx.size(); i++) begin
      checks++;
      if (a_cx[i] !== cx_tab[i % 4] || a_cy[i] !== cy_tab[(i / 4) % 3]) begin
        errors++;
        $display("FAIL coord_%0d got %h,%h want %h,%h", i, a_cx[i],
                 a_cy[i], cx_tab[i % 4], cy_tab[(i / 4) % 3]);
      end
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_logs();
    stall_n = 5;
    start = 1'b1;
    wait_done(400, ok);
    checks++; if (!ok || q_x.size() != 12) begin errors++;
      $display("FAIL bp_plots got %0d want 12", q_x.size()); end
    checks++; if (bp_viol != 0) begin errors++;
      $display("FAIL bp_hold got %0d violations want 0", bp_viol); end
    checks++; if (plot_bad != 0) begin errors++;
      $display("FAIL bp_early_plot got %0d want 0", plot_bad); end
    checks++; if (stall_edges != 60) begin errors++;
      $display("FAIL bp_stalls got %0d want 60", stall_edges); end
    if (q_cyc.size() >= 2) begin
      checks++;
      if (q_cyc[1] - q_cyc[0] != 8) begin
        errors++;
        $display("FAIL bp_period got %0d want 8", q_cyc[1] - q_cyc[0]);
      end
    end
    stall_n = 0;
    start = 1'b0;
    tick();
  endtask

  task automatic test_colour();
    bit ok;
    int exp_c[5] = '{0, 7, 7, 0, 0};
    clear_logs();
    iters_tab = '{8'd0, 8'd7, 8'd31, 8'd32, 8'd200};
    start = 1'b1;
    wait_done(200, ok);
    checks++; if (!ok || q_c.size() != 12) begin errors++;
      $display("FAIL col_plots got %0d want 12", q_c.size()); end
    for (int i = 0; i < q_c.size(); i++) begin
      checks++;
      if (q_c[i] != exp_c[i % 5]) begin
        errors++;
        $display("FAIL colour_%0d got %0d want %0d",
                 i, q_c[i], exp_c[i % 5]);
      end
    end
    start = 1'b0;
    tick();
    clear_logs();
    eng_on = 1'b0;
    eng_req_ready = 1'b0;
    eng_iters = 8'd3;
    eng_rsp_valid = 1'b1;
    tick();
    eng_rsp_valid = 1'b0;
    tick(); tick();
    checks++; if (q_x.size() != 0) begin errors++;
      $display("FAIL stray_idle got %0d plots want 0", q_x.size()); end
    start = 1'b1;
    tick();
    eng_rsp_valid = 1'b1;
    tick();
    eng_rsp_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (q_x.size() != 0 || eng_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL stray_issue got %0d plots v=%b want 0 v=1",
               q_x.size(), eng_req_valid); end
    iters_tab = '{8'd3};
    eng_on = 1'b1;
    wait_done(200, ok);
    checks++;
    if (!ok || q_x.size() != 12 || q_c[0] != 3) begin
      errors++;
      $display("FAIL stray_resume got %0d plots want 12 colour 3",
               q_x.size()); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_start_handshake();
    bit ok;
    clear_logs();
    iters_tab = '{8'd5};
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (q_x.size() >= 3) break;
    end
    start = 1'b0;
    wait_done(200, ok);
    checks++; if (!ok || q_x.size() != 12) begin errors++;
      $display("FAIL drop_mid got %0d plots want 12", q_x.size()); end
    tick();
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL drop_done_fall got %b want 0", done); end
    clear_logs();
    start = 1'b1;
    wait_done(200, ok);
    repeat (10) tick();
    checks++;
    if (done !== 1'b1 || eng_req_valid !== 1'b0 || q_x.size() != 12) begin
      errors++;
      $display("FAIL hold_start got d=%b v=%b n=%0d want 1 0 12",
               done, eng_req_valid, q_x.size()); end
    start = 1'b0;
    tick();
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL rearm_fall got %b want 0", done); end
    clear_logs();
    start = 1'b1;
    tick();
    checks++;
    if (eng_req_valid !== 1'b1 || eng_cx !== 32'd0 || eng_cy !== 32'd0) begin
      errors++;
      $display("FAIL rearm_issue got v=%b %h,%h want 1 0,0",
               eng_req_valid, eng_cx, eng_cy); end
    wait_done(200, ok);
    checks++;
    if (!ok || q_x.size() != 12 || q_x[0] != 0 || q_y[0] != 0) begin
      errors++;
      $display("FAIL rearm_frame got %0d plots want 12 from 0,0",
               q_x.size()); end
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    iters_tab = '{8'd5};
    start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (q_x.size() >= 6) break;
    end
    eng_on = 1'b0;
    tick();
    eng_req_ready = 1'b1;
    tick();
    eng_req_ready = 1'b0;
    checks++;
    if (vga_x !== 9'd1 || vga_y !== 8'd1 || vga_colour !== 3'd5 ||
        eng_cx !== 32'h0080_0000 || eng_cy !== 32'hFFC0_0000) begin
      errors++;
      $display("FAIL pre_reset got (%0d,%0d) c%0d %h,%h want (1,1) c5",
               vga_x, vga_y, vga_colour, eng_cx, eng_cy); end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (vga_x !== 9'd0 || vga_y !== 8'd0 || vga_colour !== 3'd0 ||
        eng_cx !== 32'd0 || eng_cy !== 32'd0) begin
      errors++;
      $display("FAIL async_rst_data got (%0d,%0d) c%0d %h,%h want zeros",
               vga_x, vga_y, vga_colour, eng_cx, eng_cy); end
    checks++;
    if (eng_req_valid !== 1'b0 || vga_plot !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_ctrl got v=%b p=%b d=%b want 0",
               eng_req_valid, vga_plot, done); end
    tick();
    clear_logs();
    eng_on = 1'b1;
    rstn = 1'b1;
    wait_done(200, ok);
    checks++;
    if (!ok || q_x.size() != 12 || q_x[0] != 0 || q_y[0] != 0) begin
      errors++;
      $display("FAIL post_reset got %0d plots want 12 from 0,0",
               q_x.size()); end
    checks++;
    if (a_cx.size() < 3 || a_cx[2] !== 32'h0080_0000) begin
      errors++;
      $display("FAIL post_reset_cx got %0d accepts want cx2=00800000",
               a_cx.size()); end
    start = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_small_frame();
    test_coords();
    test_backpressure();
    test_colour();
    test_start_handshake();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
